// File: rtl/mas_pkg.sv
// Shared types and helpers for the memory address sequencer.
package mas_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } mas_state_e;

  localparam logic DIR_INC = 1'b0;
  localparam logic DIR_DEC = 1'b1;

  // True when v is a non-zero power of two.
  function automatic logic is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/mas_next_addr.sv
// Combinational next-beat address: linear or wrapping, increment or decrement.
// Wrap support is compiled in only when MAS_WRAP_EN is defined.
module mas_next_addr
  import mas_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LEN_W  = 4,
  parameter int unsigned STRIDE = 1
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              dir_i,
  input  logic              wrap_i,
  output logic [ADDR_W-1:0] next_o
);

  localparam logic [ADDR_W-1:0] StrideW = ADDR_W'(STRIDE);

  logic [ADDR_W-1:0] step_addr;

`ifdef MAS_WRAP_EN
  localparam int unsigned ProdW = ADDR_W + LEN_W + 1;

  logic [LEN_W:0]      beats;
  logic [ADDR_W-1:0]   wrap_mask;

  // Wrap window spans the whole burst; a span beyond the address space masks everything.
  always_comb begin
    beats     = {1'b0, len_i} + {{LEN_W{1'b0}}, 1'b1};
    wrap_mask = ADDR_W'((ProdW'(beats) * ProdW'(STRIDE)) - ProdW'(1));
  end
`else
  logic unused_wrap_inputs;
  assign unused_wrap_inputs = ^{wrap_i, len_i};
`endif

  // Step by STRIDE modulo 2^ADDR_W, then confine to the wrap window when enabled.
  always_comb begin
    step_addr = (dir_i == DIR_DEC) ? addr_i - StrideW : addr_i + StrideW;
    next_o    = step_addr;
`ifdef MAS_WRAP_EN
    if (wrap_i && is_pow2(32'(beats))) begin
      next_o = (addr_i & ~wrap_mask) | (step_addr & wrap_mask);
    end
`endif
  end

endmodule

// File: rtl/memory_address_sequencer.sv
// Burst address sequencer: accepts a base/length/direction command and issues one word
// address per accepted memory beat. Optional wrap bursts are enabled by MAS_WRAP_EN.
module memory_address_sequencer
  import mas_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LEN_W  = 4,
  parameter int unsigned STRIDE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_dir,
  input  logic              cmd_wrap,
  input  logic              abort,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] address_output,
  output logic              mem_last,
  output logic              busy
);

  mas_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              dir_q, dir_d;
  logic              wrap_q, wrap_d;
  logic [ADDR_W-1:0] next_addr;

  mas_next_addr #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W),
    .STRIDE (STRIDE)
  ) u_next_addr (
    .addr_i (addr_q),
    .len_i  (len_q),
    .dir_i  (dir_q),
    .wrap_i (wrap_q),
    .next_o (next_addr)
  );

  // Outputs derive only from registered state, so no input-to-output paths exist.
  always_comb begin
    cmd_ready      = (state_q == IDLE);
    busy           = (state_q != IDLE);
    mem_valid      = (state_q == BURST);
    mem_last       = (state_q == BURST) && (cnt_q == '0);
    address_output = addr_q;
  end

  // Next-state: command capture in IDLE, beat advance / abort in BURST.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    dir_d   = dir_q;
    wrap_d  = wrap_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_base;
          cnt_d   = cmd_len;
          len_d   = cmd_len;
          dir_d   = cmd_dir;
          wrap_d  = cmd_wrap;
          state_d = BURST;
        end
      end
      BURST: begin
        // Abort wins over beat advance; the address holds where the burst stopped.
        if (abort) begin
          state_d = IDLE;
        end else if (mem_ready) begin
          if (cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            addr_d = next_addr;
            cnt_d  = cnt_q - LEN_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      dir_q   <= DIR_INC;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      dir_q   <= dir_d;
      wrap_q  <= wrap_d;
    end
  end

endmodule

// File: tb/tb_memory_address_sequencer.sv
// Randomised self-checking bench for memory_address_sequencer, against a burst-level model.
module tb_memory_address_sequencer;
  import mas_pkg::*;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned LEN_W  = 4;
  localparam int unsigned STRIDE = 1;
`ifdef MAS_WRAP_EN
  localparam bit WrapEn = 1'b1;
`else
  localparam bit WrapEn = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_base;
  logic [LEN_W-1:0]  cmd_len;
  logic              cmd_dir;
  logic              cmd_wrap;
  logic              abort;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] address_output;
  logic              mem_last;
  logic              busy;

  int unsigned n_vec;
  int unsigned n_err;

  memory_address_sequencer #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W),
    .STRIDE (STRIDE)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_base       (cmd_base),
    .cmd_len        (cmd_len),
    .cmd_dir        (cmd_dir),
    .cmd_wrap       (cmd_wrap),
    .abort          (abort),
    .mem_valid      (mem_valid),
    .mem_ready      (mem_ready),
    .address_output (address_output),
    .mem_last       (mem_last),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Address of beat i in a burst, computed directly from the base.
  function automatic logic [ADDR_W-1:0] model_addr(input logic [ADDR_W-1:0] base,
                                                   input int unsigned len, input logic dir,
                                                   input logic wrap, input int unsigned i);
    int unsigned n     = len + 1;
    int unsigned delta = i * STRIDE;
    int unsigned span  = n * STRIDE;
    logic [ADDR_W-1:0] lin;
    logic [ADDR_W-1:0] mask;
    lin = dir ? ADDR_W'(32'(base) - delta) : ADDR_W'(32'(base) + delta);
    if (WrapEn && wrap && ((n & (n - 1)) == 0)) begin
      mask = (span >= (32'd1 << ADDR_W)) ? '1 : ADDR_W'(span - 1);
      return (base & ~mask) | (lin & mask);
    end
    return lin;
  endfunction

  task automatic randomise_cmd_inputs();
    cmd_base = ADDR_W'($urandom);
    cmd_len  = LEN_W'($urandom);
    cmd_dir  = 1'($urandom);
    cmd_wrap = 1'($urandom);
  endtask

  // Run one burst; abort_at < 0 means no abort. Junk commands are offered while busy.
  task automatic run_burst(input logic [ADDR_W-1:0] base, input logic [LEN_W-1:0] len,
                           input logic dir, input logic wrap, input int stall,
                           input bit rand_ready, input int abort_at);
    int unsigned n = int'(len) + 1;
    int unsigned b = 0;
    int stalled = 0;
    int cycles = 0;
    bit done = 1'b0;
    bit ab;
    logic [ADDR_W-1:0] exp;
    logic [ADDR_W-1:0] hold = '0;
    check_eq("idle_cmd_ready", cmd_ready, 1);
    check_eq("idle_busy", busy, 0);
    check_eq("idle_mem_valid", mem_valid, 0);
    cmd_valid = 1'b1;
    cmd_base  = base;
    cmd_len   = len;
    cmd_dir   = dir;
    cmd_wrap  = wrap;
    abort     = 1'($urandom);  // abort while idle must not block acceptance
    mem_ready = 1'($urandom);
    step();
    cmd_valid = 1'b0;
    abort     = 1'b0;
    while (!done) begin
      exp = model_addr(base, int'(len), dir, wrap, b);
      check_eq("beat_mem_valid", mem_valid, 1);
      check_eq("beat_addr", address_output, exp);
      check_eq("beat_mem_last", mem_last, (b == n - 1));
      check_eq("beat_cmd_ready", cmd_ready, 0);
      check_eq("beat_busy", busy, 1);
      hold = exp;
      if (b == 0 && stalled < stall) mem_ready = 1'b0;
      else mem_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (b == 0 && !mem_ready) stalled++;
      ab        = (abort_at >= 0) && (b == unsigned'(abort_at));
      abort     = ab;
      cmd_valid = 1'($urandom);
      randomise_cmd_inputs();
      step();
      cmd_valid = 1'b0;
      abort     = 1'b0;
      if (ab) done = 1'b1;
      else if (mem_ready) begin
        if (b == n - 1) done = 1'b1;
        else b++;
      end
      cycles++;
      if (!done && cycles > 300) begin
        check_eq("burst_timeout", done, 1);
        done = 1'b1;
      end
    end
    check_eq("end_mem_valid", mem_valid, 0);
    check_eq("end_mem_last", mem_last, 0);
    check_eq("end_cmd_ready", cmd_ready, 1);
    check_eq("end_busy", busy, 0);
    check_eq("end_addr_hold", address_output, hold);
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_base  = '0;
    cmd_len   = '0;
    cmd_dir   = 1'b0;
    cmd_wrap  = 1'b0;
    abort     = 1'b0;
    mem_ready = 1'b0;
    #12;
    check_eq("rst_addr", address_output, 0);
    check_eq("rst_mem_valid", mem_valid, 0);
    check_eq("rst_mem_last", mem_last, 0);
    check_eq("rst_cmd_ready", cmd_ready, 1);
    check_eq("rst_busy", busy, 0);
    #10;
    reset = 1'b1;
    step();

    // Directed cases.
    run_burst(16'h1234, 4'd3, DIR_INC, 1'b0, 0, 1'b0, -1);
    run_burst(16'h0001, 4'd2, DIR_DEC, 1'b0, 0, 1'b0, -1);
    run_burst(16'h5678, 4'd1, DIR_INC, 1'b0, 3, 1'b0, -1);
    run_burst(16'h100E, 4'd3, DIR_INC, 1'b1, 0, 1'b0, -1);
    run_burst(16'hFFFE, 4'd7, DIR_INC, 1'b1, 0, 1'b0, -1);
    run_burst(16'h2003, 4'd5, DIR_DEC, 1'b1, 0, 1'b0, -1);  // 6 beats: wrap request ignored
    run_burst(16'h4000, 4'd7, DIR_INC, 1'b0, 0, 1'b0, 2);
    run_burst(16'hABCD, 4'd0, DIR_DEC, 1'b0, 2, 1'b0, -1);

    // Random bursts with random back-pressure, aborts and idle gaps.
    for (int k = 0; k < 80; k++) begin
      logic [LEN_W-1:0] l;
      int ab_at;
      l     = LEN_W'($urandom);
      ab_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(l))) : -1;
      run_burst(ADDR_W'($urandom), l, 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
                1'b1, ab_at);
      if ($urandom_range(0, 1) == 1) step();
    end

    // Reset in the middle of a burst must clear outputs without a clock edge.
    cmd_valid = 1'b1;
    cmd_base  = 16'h3000;
    cmd_len   = 4'd7;
    cmd_dir   = DIR_INC;
    cmd_wrap  = 1'b0;
    mem_ready = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    check_eq("pre_rst_addr", address_output, 16'h3002);
    #3;
    reset = 1'b0;
    #1;
    check_eq("async_rst_addr", address_output, 0);
    check_eq("async_rst_mem_valid", mem_valid, 0);
    check_eq("async_rst_mem_last", mem_last, 0);
    check_eq("async_rst_cmd_ready", cmd_ready, 1);
    check_eq("async_rst_busy", busy, 0);
    #2;
    reset = 1'b1;
    step();
    run_burst(16'h0010, 4'd2, DIR_INC, 1'b0, 1, 1'b1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
